// File: rtl/dpb_slot_reader.sv
// dpb_slot_reader: pops packet descriptors from a small FIFO, streams the
// slot's words out of a 2-cycle-latency BRAM to a UDP packet builder and
// releases the slot once the builder reports the packet sent.
// Optional feature macro: DPB_SLOT_READER_IPV4_SIGN_EN (incrementing IPv4 id).
module dpb_slot_reader #(
  parameter int DATA_W     = 128,
  parameter int SLOT_AW    = 4,
  parameter int WORD_AW    = 7,
  parameter int DESC_DEPTH = 4,
  parameter int EN_TAIL    = 4
) (
  input  logic                       i_pclk,
  input  logic                       i_rst,
  output logic [SLOT_AW+WORD_AW-1:0] o_dpb_addr,
  output logic                       o_dpb_cea,
  input  logic [DATA_W-1:0]          i_dpb_rd_data,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic [SLOT_AW-1:0]         i_req_slot,
  input  logic [WORD_AW-1:0]         i_req_word_cnt,
  input  logic [5:0]                 i_req_byte_cnt,
  input  logic [7:0]                 i_req_udp_rank,
  input  logic                       i_req_last,
  output logic                       o_udp_en,
  output logic [DATA_W-1:0]          o_udp_data,
  output logic                       o_udp_last_frame_flag,
  output logic [14:0]                o_udp_frame_rank,
  output logic [15:0]                o_udp_jpeg_len,
  output logic [15:0]                o_udp_ipv4_sign,
  input  logic                       i_udp_data_upd_req,
  input  logic                       i_udp_frame_down,
  output logic                       o_done,
  output logic [SLOT_AW-1:0]         o_done_slot
);

  localparam int PTR_W  = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;
  localparam int DESC_W = SLOT_AW + WORD_AW + 6 + 8 + 1;
  localparam int TAIL_W = (EN_TAIL < 1) ? 1 : $clog2(EN_TAIL + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DONE} state_t;

  state_t r_state, w_next;

  logic [DESC_W-1:0]         r_mem [DESC_DEPTH];
  logic [PTR_W-1:0]          r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]            r_count;
  logic                      w_full, w_push, w_pop;
  logic [DESC_W-1:0]         w_head;
  logic [SLOT_AW-1:0]        w_head_slot;
  logic [WORD_AW-1:0]        w_head_wc;
  logic [5:0]                w_head_bc;
  logic [7:0]                w_head_rank;
  logic                      w_head_last;
  logic [15:0]               w_head_len;

  logic [SLOT_AW-1:0]        r_slot;
  logic [WORD_AW-1:0]        r_word;
  logic [15:0]               r_len;
  logic [7:0]                r_rank;
  logic                      r_last;
  logic                      r_load_cnt;
  logic                      r_upd_d, r_fd_d;
  logic                      w_upd_edge, w_fd_edge;
  logic [TAIL_W-1:0]         r_tail;

  assign w_full   = (r_count == (PTR_W+1)'(DESC_DEPTH));
  assign w_push   = i_req_valid & ~w_full;
  assign w_pop    = (r_state == S_IDLE) & (r_count != '0);
  assign w_head   = r_mem[r_rd_ptr];
  assign {w_head_slot, w_head_wc, w_head_bc, w_head_rank, w_head_last} = w_head;
  assign w_head_len = 16'(16'(w_head_wc) * 16'(DATA_W / 8)) + 16'(w_head_bc);

  assign w_upd_edge = i_udp_data_upd_req & ~r_upd_d;
  assign w_fd_edge  = i_udp_frame_down & ~r_fd_d;

  // Descriptor storage; contents are don't-care until written
  always_ff @(posedge i_pclk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_req_slot, i_req_word_cnt, i_req_byte_cnt,
                                    i_req_udp_rank, i_req_last};
  end

  // FIFO pointers and occupancy; simultaneous push/pop leaves count unchanged
  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge i_pclk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (r_count != '0) w_next = S_LOAD;
      S_LOAD:   if (r_load_cnt)    w_next = S_STREAM;
      S_STREAM: if (w_fd_edge)     w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // FSM outputs; enable is forced low in DONE even if a tail is still running
  always_comb begin
    o_dpb_cea   = (r_state == S_LOAD) | (r_state == S_STREAM);
    o_done      = (r_state == S_DONE);
    o_done_slot = (r_state == S_DONE) ? r_slot : '0;
    o_udp_en    = (r_state != S_DONE) & (o_dpb_cea | (r_tail != '0));
  end

  // Packet context, word pointer, edge detectors and enable tail
  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      r_slot     <= '0;
      r_word     <= '0;
      r_len      <= '0;
      r_rank     <= '0;
      r_last     <= 1'b0;
      r_load_cnt <= 1'b0;
      r_upd_d    <= 1'b0;
      r_fd_d     <= 1'b0;
      r_tail     <= '0;
    end else begin
      r_upd_d    <= i_udp_data_upd_req;
      r_fd_d     <= i_udp_frame_down;
      r_load_cnt <= (r_state == S_LOAD) ? ~r_load_cnt : 1'b0;
      if (w_pop) begin
        r_slot <= w_head_slot;
        r_word <= '0;
        r_len  <= w_head_len;
        r_rank <= w_head_rank;
        r_last <= w_head_last;
      end else if (r_state == S_DONE) begin
        r_word <= '0;
      end else if ((r_state == S_STREAM) && w_upd_edge && !w_fd_edge && (r_word != '1)) begin
        r_word <= r_word + WORD_AW'(1);
      end
      if (r_state == S_DONE)  r_tail <= TAIL_W'(EN_TAIL);
      else if (r_tail != '0)  r_tail <= r_tail - TAIL_W'(1);
    end
  end

`ifdef DPB_SLOT_READER_IPV4_SIGN_EN
  logic [15:0] r_sign;
  // IPv4 identification advances once per released packet
  always_ff @(posedge i_pclk) begin
    if (i_rst)                  r_sign <= '0;
    else if (r_state == S_DONE) r_sign <= r_sign + 16'd1;
  end
  assign o_udp_ipv4_sign = r_sign;
`else
  assign o_udp_ipv4_sign = '0;
`endif

  assign o_dpb_addr            = {r_slot, r_word};
  assign o_req_ready           = ~w_full;
  assign o_udp_data            = i_dpb_rd_data;
  assign o_udp_last_frame_flag = r_last;
  assign o_udp_frame_rank      = {7'd0, r_rank};
  assign o_udp_jpeg_len        = r_len;

endmodule

// File: tb/tb_dpb_slot_reader.sv
// Self-checking bench for dpb_slot_reader: table vectors, hand-written
// corner sequences and randomized packets against an arithmetic model.
module tb_dpb_slot_reader;

  localparam int DATA_W  = 128;
  localparam int SLOT_AW = 4;
  localparam int WORD_AW = 7;
  localparam int EN_TAIL = 4;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [SLOT_AW+WORD_AW-1:0] dpb_addr;
  logic                       dpb_cea;
  logic [DATA_W-1:0]          rd_data;
  logic                       req_valid, req_ready;
  logic [SLOT_AW-1:0]         req_slot;
  logic [WORD_AW-1:0]         req_wc;
  logic [5:0]                 req_bc;
  logic [7:0]                 req_rank;
  logic                       req_last;
  logic                       udp_en, udp_flag;
  logic [DATA_W-1:0]          udp_data;
  logic [14:0]                udp_rank;
  logic [15:0]                udp_len, udp_sign;
  logic                       upd, fd, done;
  logic [SLOT_AW-1:0]         done_slot;

  int checks = 0;
  int errors = 0;
  int sign_model = 0;

  dpb_slot_reader #(.DATA_W(DATA_W), .SLOT_AW(SLOT_AW), .WORD_AW(WORD_AW),
                    .DESC_DEPTH(4), .EN_TAIL(EN_TAIL)) dut (
    .i_pclk(clk), .i_rst(rst), .o_dpb_addr(dpb_addr), .o_dpb_cea(dpb_cea),
    .i_dpb_rd_data(rd_data), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_slot(req_slot), .i_req_word_cnt(req_wc), .i_req_byte_cnt(req_bc),
    .i_req_udp_rank(req_rank), .i_req_last(req_last), .o_udp_en(udp_en),
    .o_udp_data(udp_data), .o_udp_last_frame_flag(udp_flag),
    .o_udp_frame_rank(udp_rank), .o_udp_jpeg_len(udp_len),
    .o_udp_ipv4_sign(udp_sign), .i_udp_data_upd_req(upd),
    .i_udp_frame_down(fd), .o_done(done), .o_done_slot(done_slot));

  always #5 clk = ~clk;

  typedef struct {
    int slot; int wc; int bc; int rank; int last; int nupd;
    int exp_len; int exp_addr;
  } vec_t;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int exp_sign();
`ifdef DPB_SLOT_READER_IPV4_SIGN_EN
    return sign_model & 16'hFFFF;
`else
    return 0;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; upd = 1'b0; fd = 1'b0;
    req_slot = '0; req_wc = '0; req_bc = '0; req_rank = '0; req_last = 1'b0;
    tick(); tick();
    rst = 1'b0;
    sign_model = 0;
  endtask

  task automatic chk_reset_values();
    chk("rst_ready", req_ready, 1);
    chk("rst_en", udp_en, 0);
    chk("rst_cea", dpb_cea, 0);
    chk("rst_addr", dpb_addr, 0);
    chk("rst_done", done, 0);
    chk("rst_done_slot", done_slot, 0);
    chk("rst_len", udp_len, 0);
    chk("rst_rank", udp_rank, 0);
    chk("rst_flag", udp_flag, 0);
    chk("rst_sign", udp_sign, 0);
  endtask

  task automatic push(input int slot, input int wc, input int bc, input int rank, input int last);
    req_valid = 1'b1;
    req_slot = SLOT_AW'(slot); req_wc = WORD_AW'(wc); req_bc = 6'(bc);
    req_rank = 8'(rank); req_last = last[0];
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_load();
    int k = 0;
    while (dpb_cea !== 1'b1 && k < 20) begin tick(); k++; end
    chk("load_seen", dpb_cea, 1);
  endtask

  // Full single-packet transaction with field, address, done and tail checks
  task automatic run_packet(input int slot, input int wc, input int bc, input int rank,
                            input int last, input int nupd, input int noise);
    int exp_len, exp_word;
    exp_len  = (wc * (DATA_W / 8) + bc) % 65536;
    exp_word = (nupd > 127) ? 127 : nupd;
    push(slot, wc, bc, rank, last);
    wait_load();
    chk("load_len", udp_len, exp_len);
    chk("load_rank", udp_rank, rank);
    chk("load_flag", udp_flag, last);
    chk("load_addr", dpb_addr, slot * 128);
    chk("load_en", udp_en, 1);
    chk("load_sign", udp_sign, exp_sign());
    if (noise != 0) upd = 1'b1;
    tick();
    upd = 1'b0;
    tick();
    chk("stream_cea", dpb_cea, 1);
    chk("stream_addr0", dpb_addr, slot * 128);
    for (int i = 0; i < nupd; i++) begin
      upd = 1'b1; tick(); upd = 1'b0; tick();
    end
    chk("stream_addr", dpb_addr, slot * 128 + exp_word);
    chk("stream_data", udp_data, rd_data);
    fd = 1'b1; tick(); fd = 1'b0;
    sign_model++;
    chk("done", done, 1);
    chk("done_slot", done_slot, slot);
    chk("done_en", udp_en, 0);
    chk("done_cea", dpb_cea, 0);
    for (int t = 0; t < EN_TAIL; t++) begin
      tick();
      chk("tail_en", udp_en, 1);
      chk("tail_done", done, 0);
    end
    tick();
    chk("tail_end_en", udp_en, 0);
  endtask

  // Serve an already-queued packet with no stream edges
  task automatic serve(input int exp_slot);
    wait_load();
    tick(); tick();
    fd = 1'b1; tick(); fd = 1'b0;
    sign_model++;
    chk("serve_done", done, 1);
    chk("serve_slot", done_slot, exp_slot);
    tick();
  endtask

  initial begin
    vec_t tbl[4];
    int seen;
    tbl[0] = '{slot:3,  wc:5,   bc:4,  rank:7,   last:0, nupd:5,   exp_len:84,   exp_addr:'h185};
    tbl[1] = '{slot:0,  wc:0,   bc:0,  rank:0,   last:1, nupd:0,   exp_len:0,    exp_addr:'h000};
    tbl[2] = '{slot:15, wc:127, bc:63, rank:255, last:1, nupd:130, exp_len:2095, exp_addr:'h7FF};
    tbl[3] = '{slot:9,  wc:2,   bc:17, rank:1,   last:0, nupd:3,   exp_len:49,   exp_addr:'h483};
    rd_data = {4{32'hA5C3_0F1E}};

    do_reset();
    chk_reset_values();

    // Table vectors: load-time fields and final address
    for (int v = 0; v < 4; v++) begin
      push(tbl[v].slot, tbl[v].wc, tbl[v].bc, tbl[v].rank, tbl[v].last);
      wait_load();
      chk("tbl_len", udp_len, tbl[v].exp_len);
      chk("tbl_rank", udp_rank, tbl[v].rank);
      chk("tbl_flag", udp_flag, tbl[v].last);
      tick(); tick();
      for (int i = 0; i < tbl[v].nupd; i++) begin
        upd = 1'b1; tick(); upd = 1'b0; tick();
      end
      chk("tbl_addr", dpb_addr, tbl[v].exp_addr);
      fd = 1'b1; tick(); fd = 1'b0;
      sign_model++;
      chk("tbl_done_slot", done_slot, tbl[v].slot);
      for (int t = 0; t <= EN_TAIL; t++) tick();
    end

    // Full transaction including the tail and LOAD-time noise
    run_packet(3, 5, 4, 7, 0, 5, 1);

    // FIFO fills while busy: ready drops after 4 pushes, 5th dropped
    push(1, 1, 0, 0, 0);
    wait_load();
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("fill_ready", req_ready, (i < 4) ? 1 : 0);
      push(2 + i, 1, 0, i, 0);
    end
    fd = 1'b1; tick(); fd = 1'b0;
    sign_model++;
    chk("fill_done_a", done_slot, 1);
    tick();
    for (int i = 0; i < 4; i++) serve(2 + i);
    seen = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (dpb_cea) seen = 1; end
    chk("fifth_dropped", seen, 0);

    // Simultaneous upd_req and frame_down edges: no increment, DONE next
    push(7, 3, 0, 0, 0);
    wait_load();
    tick(); tick();
    upd = 1'b1; tick(); upd = 1'b0; tick();
    upd = 1'b1; fd = 1'b1; tick(); upd = 1'b0; fd = 1'b0;
    sign_model++;
    chk("simul_done", done, 1);
    chk("simul_addr", dpb_addr, 7 * 128 + 1);
    for (int t = 0; t <= EN_TAIL; t++) tick();

    // Reset in STREAM drops the packet without o_done
    push(6, 3, 2, 9, 1);
    wait_load();
    tick(); tick();
    upd = 1'b1; tick(); upd = 1'b0; tick();
    rst = 1'b1; tick(); rst = 1'b0;
    sign_model = 0;
    chk_reset_values();
    seen = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (done) seen = 1; end
    chk("rst_no_done", seen, 0);
    run_packet(10, 4, 1, 3, 1, 2, 0);

    // Randomized packets against the arithmetic model
    for (int r = 0; r < 20; r++) begin
      int n;
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(125, 132)) : int'($urandom_range(0, 12));
      run_packet(int'($urandom_range(0, 15)), int'($urandom_range(0, 127)),
                 int'($urandom_range(0, 63)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 1)), n, int'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
